// File: rtl/tri_bbox_pkg.sv
// ============================================================
// tri_bbox_pkg: shared graphics defaults and scanner state type
// Rev 1.0
// ============================================================
`default_nettype none

package tri_bbox_pkg;
  localparam int HRES_DEFAULT        = 320;
  localparam int VRES_DEFAULT        = 180;
  localparam int COLOR_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2,
    ST_MARK  = 2'd3
  } scan_state_t;
endpackage

`default_nettype wire

// File: rtl/tri_bbox_clamp.sv
// ============================================================
// tri_bbox_clamp: signed min/max of three vertices, clamped to screen
// Rev 1.0
// ============================================================
`default_nettype none

module tri_bbox_clamp
  import tri_bbox_pkg::*;
#(
  parameter int X_WIDTH = 18,
  parameter int Y_WIDTH = 20,
  parameter int HRES    = HRES_DEFAULT,
  parameter int VRES    = VRES_DEFAULT
) (
  input  logic [3*X_WIDTH-1:0]     x,
  input  logic [3*Y_WIDTH-1:0]     y,
  output logic [$clog2(HRES)-1:0]  min_x,
  output logic [$clog2(HRES)-1:0]  max_x,
  output logic [$clog2(VRES)-1:0]  min_y,
  output logic [$clog2(VRES)-1:0]  max_y,
  output logic                     empty
);
  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);
  localparam logic signed [X_WIDTH-1:0] C_XMAX = X_WIDTH'(HRES - 1);
  localparam logic signed [Y_WIDTH-1:0] C_YMAX = Y_WIDTH'(VRES - 1);

  logic signed [X_WIDTH-1:0] w_x0, w_x1, w_x2, w_minx, w_maxx, w_cminx, w_cmaxx;
  logic signed [Y_WIDTH-1:0] w_y0, w_y1, w_y2, w_miny, w_maxy, w_cminy, w_cmaxy;

  assign w_x0 = x[0*X_WIDTH +: X_WIDTH];
  assign w_x1 = x[1*X_WIDTH +: X_WIDTH];
  assign w_x2 = x[2*X_WIDTH +: X_WIDTH];
  assign w_y0 = y[0*Y_WIDTH +: Y_WIDTH];
  assign w_y1 = y[1*Y_WIDTH +: Y_WIDTH];
  assign w_y2 = y[2*Y_WIDTH +: Y_WIDTH];

  always_comb begin
    w_minx = w_x0;
    w_maxx = w_x0;
    w_miny = w_y0;
    w_maxy = w_y0;
    if (w_x1 < w_minx) w_minx = w_x1;
    if (w_x2 < w_minx) w_minx = w_x2;
    if (w_x1 > w_maxx) w_maxx = w_x1;
    if (w_x2 > w_maxx) w_maxx = w_x2;
    if (w_y1 < w_miny) w_miny = w_y1;
    if (w_y2 < w_miny) w_miny = w_y2;
    if (w_y1 > w_maxy) w_maxy = w_y1;
    if (w_y2 > w_maxy) w_maxy = w_y2;
  end

  // Clamp at full signed width; truncation to counter width is only safe afterwards.
  assign w_cminx = w_minx[X_WIDTH-1] ? '0 : w_minx;
  assign w_cmaxx = (w_maxx > C_XMAX) ? C_XMAX : w_maxx;
  assign w_cminy = w_miny[Y_WIDTH-1] ? '0 : w_miny;
  assign w_cmaxy = (w_maxy > C_YMAX) ? C_YMAX : w_maxy;

  assign empty = w_maxx[X_WIDTH-1] || w_maxy[Y_WIDTH-1] ||
                 (w_minx > C_XMAX) || (w_miny > C_YMAX);

  assign min_x = HW'(w_cminx);
  assign max_x = HW'(w_cmaxx);
  assign min_y = VW'(w_cminy);
  assign max_y = VW'(w_cmaxy);
endmodule

`default_nettype wire

// File: rtl/tri_bbox_scanner.sv
// ============================================================
// tri_bbox_scanner: streams the clamped bounding box of a triangle
// Rev 1.0
// ============================================================
`default_nettype none

module tri_bbox_scanner
  import tri_bbox_pkg::*;
#(
  parameter int X_WIDTH     = 18,
  parameter int Y_WIDTH     = 20,
  parameter int ZWIDTH      = 16,
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEFAULT,
  parameter int HRES        = HRES_DEFAULT,
  parameter int VRES        = VRES_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic                     last_pixel_in,
  input  logic [3*X_WIDTH-1:0]     x_in,
  input  logic [3*Y_WIDTH-1:0]     y_in,
  input  logic [3*ZWIDTH-1:0]      z_in,
  input  logic [COLOR_WIDTH-1:0]   color_in,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(HRES)-1:0]  hcount_out,
  output logic [$clog2(VRES)-1:0]  vcount_out,
  output logic [3*X_WIDTH-1:0]     tri_x_out,
  output logic [3*Y_WIDTH-1:0]     tri_y_out,
  output logic [3*ZWIDTH-1:0]      tri_z_out,
  output logic [COLOR_WIDTH-1:0]   color_out,
  output logic                     first_pixel_out,
  output logic                     last_pixel_out,
  output logic                     frame_end_out,
  output logic [15:0]              culled_count_out
);
  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);

  scan_state_t r_state, w_state_nxt;

  logic [3*X_WIDTH-1:0]   r_tri_x;
  logic [3*Y_WIDTH-1:0]   r_tri_y;
  logic [3*ZWIDTH-1:0]    r_tri_z;
  logic [COLOR_WIDTH-1:0] r_color;
  logic [HW-1:0]          r_hcount, r_minx, r_maxx;
  logic [VW-1:0]          r_vcount, r_miny, r_maxy;
  logic [15:0]            r_culled;

  logic [HW-1:0] w_minx, w_maxx;
  logic [VW-1:0] w_miny, w_maxy;
  logic          w_empty, w_h_end, w_v_end;

  tri_bbox_clamp #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .HRES    (HRES),
    .VRES    (VRES)
  ) u_clamp (
    .x     (r_tri_x),
    .y     (r_tri_y),
    .min_x (w_minx),
    .max_x (w_maxx),
    .min_y (w_miny),
    .max_y (w_maxy),
    .empty (w_empty)
  );

  assign w_h_end = (r_hcount == r_maxx);
  assign w_v_end = (r_vcount == r_maxy);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (valid_in) w_state_nxt = last_pixel_in ? ST_MARK : ST_SETUP;
      ST_SETUP: w_state_nxt = w_empty ? ST_IDLE : ST_SCAN;
      ST_SCAN:  if (ready_in && w_h_end && w_v_end) w_state_nxt = ST_IDLE;
      ST_MARK:  if (ready_in) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tri_x  <= '0;
      r_tri_y  <= '0;
      r_tri_z  <= '0;
      r_color  <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_minx   <= '0;
      r_maxx   <= '0;
      r_miny   <= '0;
      r_maxy   <= '0;
      r_culled <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_tri_x <= x_in;
            r_tri_y <= y_in;
            r_tri_z <= z_in;
            r_color <= color_in;
          end
        end
        ST_SETUP: begin
          if (w_empty) begin
            r_culled <= r_culled + 1'b1;
          end else begin
            r_minx   <= w_minx;
            r_maxx   <= w_maxx;
            r_miny   <= w_miny;
            r_maxy   <= w_maxy;
            r_hcount <= w_minx;
            r_vcount <= w_miny;
          end
        end
        ST_SCAN: begin
          if (ready_in) begin
            if (!w_h_end) begin
              r_hcount <= r_hcount + 1'b1;
            end else if (!w_v_end) begin
              r_hcount <= r_minx;
              r_vcount <= r_vcount + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // All handshake outputs derive from registers so they hold steady during a stall.
  assign ready_out        = (r_state == ST_IDLE);
  assign valid_out        = (r_state == ST_SCAN) || (r_state == ST_MARK);
  assign frame_end_out    = (r_state == ST_MARK);
  assign first_pixel_out  = (r_state == ST_SCAN) && (r_hcount == r_minx) && (r_vcount == r_miny);
  assign last_pixel_out   = (r_state == ST_SCAN) && w_h_end && w_v_end;
  assign hcount_out       = r_hcount;
  assign vcount_out       = r_vcount;
  assign tri_x_out        = r_tri_x;
  assign tri_y_out        = r_tri_y;
  assign tri_z_out        = r_tri_z;
  assign color_out        = r_color;
  assign culled_count_out = r_culled;
endmodule

`default_nettype wire

// File: tb/tb_tri_bbox_scanner.sv
// ============================================================
// tb_tri_bbox_scanner: directed self-checking bench for tri_bbox_scanner
// Rev 1.0
// ============================================================
`default_nettype none

module tb_tri_bbox_scanner;
  localparam int X_WIDTH     = 18;
  localparam int Y_WIDTH     = 20;
  localparam int ZWIDTH      = 16;
  localparam int COLOR_WIDTH = 16;
  localparam int HRES        = 320;
  localparam int VRES        = 180;
  localparam int HW          = $clog2(HRES);
  localparam int VW          = $clog2(VRES);
  localparam int HOLD_W      = 1 + HW + VW + 2 + 3*X_WIDTH;

  logic                    clk_in = 1'b0;
  logic                    rst_n_in;
  logic                    valid_in;
  logic                    ready_out;
  logic                    last_pixel_in;
  logic [3*X_WIDTH-1:0]    x_in;
  logic [3*Y_WIDTH-1:0]    y_in;
  logic [3*ZWIDTH-1:0]     z_in;
  logic [COLOR_WIDTH-1:0]  color_in;
  logic                    valid_out;
  logic                    ready_in;
  logic [HW-1:0]           hcount_out;
  logic [VW-1:0]           vcount_out;
  logic [3*X_WIDTH-1:0]    tri_x_out;
  logic [3*Y_WIDTH-1:0]    tri_y_out;
  logic [3*ZWIDTH-1:0]     tri_z_out;
  logic [COLOR_WIDTH-1:0]  color_out;
  logic                    first_pixel_out;
  logic                    last_pixel_out;
  logic                    frame_end_out;
  logic [15:0]             culled_count_out;

  tri_bbox_scanner #(
    .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .ZWIDTH(ZWIDTH),
    .COLOR_WIDTH(COLOR_WIDTH), .HRES(HRES), .VRES(VRES)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
    .last_pixel_in(last_pixel_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .color_in(color_in), .valid_out(valid_out), .ready_in(ready_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .tri_x_out(tri_x_out),
    .tri_y_out(tri_y_out), .tri_z_out(tri_z_out), .color_out(color_out),
    .first_pixel_out(first_pixel_out), .last_pixel_out(last_pixel_out),
    .frame_end_out(frame_end_out), .culled_count_out(culled_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  int got_h[$];
  int got_v[$];
  bit got_f[$];
  bit got_l[$];
  int first_cyc;

  task automatic send_tri(input int x0, input int x1, input int x2,
                          input int y0, input int y1, input int y2, input bit mark);
    @(negedge clk_in);
    n_checks++;
    if (ready_out !== 1'b1) $display("FAIL send_ready: ready_out=%b expected 1", ready_out);
    else n_pass++;
    x_in          = {X_WIDTH'(x2), X_WIDTH'(x1), X_WIDTH'(x0)};
    y_in          = {Y_WIDTH'(y2), Y_WIDTH'(y1), Y_WIDTH'(y0)};
    z_in          = {16'd300, 16'd200, 16'd100};
    color_in      = 16'hBEEF;
    last_pixel_in = mark;
    valid_in      = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in      = 1'b0;
    last_pixel_in = 1'b0;
  endtask

  // Records accepted beats; with toggle set, ready_in alternates and stalled outputs are compared.
  task automatic collect(input bit toggle);
    bit done = 1'b0;
    bit have_hold = 1'b0;
    logic [HOLD_W-1:0] held = '0;
    logic [HOLD_W-1:0] now;
    got_h.delete(); got_v.delete(); got_f.delete(); got_l.delete();
    first_cyc = -1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk_in);
      ready_in = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      now = {valid_out, hcount_out, vcount_out, first_pixel_out, last_pixel_out, tri_x_out};
      if (have_hold) begin
        n_checks++;
        if (now !== held) $display("FAIL stall_hold: outputs=%h expected %h", now, held);
        else n_pass++;
        have_hold = 1'b0;
      end
      if (valid_out === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        if (ready_in) begin
          got_h.push_back(int'(hcount_out));
          got_v.push_back(int'(vcount_out));
          got_f.push_back(first_pixel_out);
          got_l.push_back(last_pixel_out);
          if (last_pixel_out === 1'b1) done = 1'b1;
        end else begin
          held = now;
          have_hold = 1'b1;
        end
      end
    end
    ready_in = 1'b1;
    n_checks++;
    if (!done) $display("FAIL scan_timeout: last beat seen=%b expected 1", done);
    else n_pass++;
    @(negedge clk_in);
    #1;
    n_checks++;
    if ({ready_out, valid_out} !== 2'b10)
      $display("FAIL back_to_idle: ready/valid=%b%b expected 10", ready_out, valid_out);
    else n_pass++;
  endtask

  task automatic check_beats(input string name, input int minx, input int maxx,
                             input int miny, input int maxy);
    int n = (maxx - minx + 1) * (maxy - miny + 1);
    int idx = 0;
    n_checks++;
    if (got_h.size() != n) $display("FAIL %s_count: beats=%0d expected %0d", name, got_h.size(), n);
    else n_pass++;
    n_checks++;
    if (first_cyc != 1) $display("FAIL %s_latency: first valid cycle=%0d expected 1", name, first_cyc);
    else n_pass++;
    for (int v = miny; v <= maxy; v++) begin
      for (int h = minx; h <= maxx; h++) begin
        if (idx < got_h.size()) begin
          n_checks++;
          if (got_h[idx] != h || got_v[idx] != v || got_f[idx] != (idx == 0) || got_l[idx] != (idx == n-1))
            $display("FAIL %s_beat%0d: (%0d,%0d) f%0b l%0b expected (%0d,%0d) f%0b l%0b", name, idx,
                     got_h[idx], got_v[idx], got_f[idx], got_l[idx], h, v, idx == 0, idx == n-1);
          else n_pass++;
        end
        idx++;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ready_out, valid_out, first_pixel_out, last_pixel_out, frame_end_out} !== 5'b10000)
      $display("FAIL reset_flags: rdy/vld/first/last/fe=%b%b%b%b%b expected 10000",
               ready_out, valid_out, first_pixel_out, last_pixel_out, frame_end_out);
    else n_pass++;
    n_checks++;
    if (hcount_out !== '0 || vcount_out !== '0 || culled_count_out !== 16'd0)
      $display("FAIL reset_counts: h=%0d v=%0d culled=%0d expected 0 0 0", hcount_out, vcount_out, culled_count_out);
    else n_pass++;
    n_checks++;
    if (tri_x_out !== '0 || tri_y_out !== '0 || tri_z_out !== '0 || color_out !== '0)
      $display("FAIL reset_fields: x=%h y=%h z=%h c=%h expected 0", tri_x_out, tri_y_out, tri_z_out, color_out);
    else n_pass++;
  endtask

  task automatic test_basic();
    send_tri(2, 4, 3, 1, 1, 2, 1'b0);
    n_checks++;
    if ({ready_out, valid_out} !== 2'b00)
      $display("FAIL basic_setup: ready/valid=%b%b expected 00", ready_out, valid_out);
    else n_pass++;
    n_checks++;
    if (tri_x_out !== {18'd3, 18'd4, 18'd2} || color_out !== 16'hBEEF || tri_z_out !== {16'd300, 16'd200, 16'd100})
      $display("FAIL basic_capture: x=%h c=%h expected %h beef", tri_x_out, color_out, {18'd3, 18'd4, 18'd2});
    else n_pass++;
    collect(1'b0);
    check_beats("basic", 2, 4, 1, 2);
  endtask

  task automatic test_stall();
    send_tri(2, 4, 3, 1, 1, 2, 1'b0);
    collect(1'b1);
    check_beats("stall", 2, 4, 1, 2);
  endtask

  task automatic test_clamp();
    send_tri(-5, 1, 0, 179, 200, 178, 1'b0);
    collect(1'b0);
    check_beats("clamp", 0, 1, 178, 179);
  endtask

  task automatic test_cull();
    send_tri(400, 410, 420, 0, 0, 0, 1'b0);
    n_checks++;
    if ({ready_out, valid_out} !== 2'b00)
      $display("FAIL cull_setup: ready/valid=%b%b expected 00", ready_out, valid_out);
    else n_pass++;
    @(posedge clk_in); #1;
    n_checks++;
    if ({ready_out, valid_out} !== 2'b10 || culled_count_out !== 16'd1)
      $display("FAIL cull_right: rdy/vld=%b%b culled=%0d expected 10 1", ready_out, valid_out, culled_count_out);
    else n_pass++;
    send_tri(-10, -3, -1, 5, 5, 5, 1'b0);
    @(posedge clk_in); #1;
    n_checks++;
    if (culled_count_out !== 16'd2 || valid_out !== 1'b0)
      $display("FAIL cull_left: culled=%0d vld=%b expected 2 0", culled_count_out, valid_out);
    else n_pass++;
    send_tri(0, 10, 5, 180, 190, 185, 1'b0);
    @(posedge clk_in); #1;
    n_checks++;
    if (culled_count_out !== 16'd3 || valid_out !== 1'b0)
      $display("FAIL cull_below: culled=%0d vld=%b expected 3 0", culled_count_out, valid_out);
    else n_pass++;
  endtask

  task automatic test_marker();
    ready_in = 1'b0;
    send_tri(7, 8, 9, 7, 8, 9, 1'b1);
    n_checks++;
    if ({valid_out, frame_end_out, last_pixel_out, ready_out} !== 4'b1100)
      $display("FAIL mark_beat: vld/fe/last/rdy=%b%b%b%b expected 1100", valid_out, frame_end_out, last_pixel_out, ready_out);
    else n_pass++;
    @(posedge clk_in); #1;
    n_checks++;
    if ({valid_out, frame_end_out} !== 2'b11)
      $display("FAIL mark_hold: vld/fe=%b%b expected 11", valid_out, frame_end_out);
    else n_pass++;
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    n_checks++;
    if ({valid_out, frame_end_out, ready_out} !== 3'b001)
      $display("FAIL mark_done: vld/fe/rdy=%b%b%b expected 001", valid_out, frame_end_out, ready_out);
    else n_pass++;
    send_tri(5, 5, 5, 7, 7, 7, 1'b0);
    collect(1'b0);
    check_beats("degen", 5, 5, 7, 7);
  endtask

  task automatic test_reset_mid_scan();
    bit found = 1'b0;
    send_tri(2, 4, 3, 1, 1, 2, 1'b0);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_in); #1;
      if (valid_out === 1'b1 && hcount_out == 9'd4 && vcount_out == 8'd1) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL rst_find_pixel3: found=%b expected 1", found);
    else n_pass++;
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({valid_out, ready_out, first_pixel_out, last_pixel_out} !== 4'b0100 ||
        hcount_out !== '0 || vcount_out !== '0 || culled_count_out !== 16'd0 || tri_x_out !== '0)
      $display("FAIL rst_mid_scan: vld/rdy=%b%b h=%0d v=%0d culled=%0d expected 01 0 0 0",
               valid_out, ready_out, hcount_out, vcount_out, culled_count_out);
    else n_pass++;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    send_tri(10, 11, 10, 20, 20, 21, 1'b0);
    collect(1'b0);
    check_beats("after_rst", 10, 11, 20, 21);
  endtask

  initial begin
    rst_n_in      = 1'b0;
    valid_in      = 1'b0;
    ready_in      = 1'b1;
    last_pixel_in = 1'b0;
    x_in          = '0;
    y_in          = '0;
    z_in          = '0;
    color_in      = '0;
    repeat (2) @(negedge clk_in);
    test_reset();
    rst_n_in = 1'b1;
    test_basic();
    test_stall();
    test_clamp();
    test_cull();
    test_marker();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
